// File: rtl/ct_loader_pkg.sv
// Shared decrypt constants: default element count and width, derived
// geometry helpers for the ciphertext RAM, and the loader state encoding.
package ct_loader_pkg;

   localparam int CT_N = 7;   // ciphertext elements per load
   localparam int CT_M = 4;   // element width in bits
   localparam int CT_D = 5;   // elements packed per RAM row

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int ct_clog2(input int v);
      int r;
      r = 0;
      for (int p = 1; p < v; p = p * 2) r = r + 1;
      return r;
   endfunction

   // Packed row width.
   function automatic int ct_width(input int m, input int d);
      return m * d;
   endfunction

   // Number of RAM rows needed to hold n elements, d per row.
   function automatic int ct_depth(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

   // Row address width, never narrower than one bit.
   function automatic int ct_aw(input int n, input int d);
      int a;
      a = ct_clog2(ct_depth(n, d));
      return (a < 1) ? 1 : a;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } ct_state_t;

endpackage

// File: rtl/ct_loader.sv
// Ciphertext loader: accepts N elements over a valid/ready stream, packs
// them D per row (slot 0 at the LSBs) and writes each completed row to the
// ciphertext single-port RAM, then pulses done to kick off decryption.
module ct_loader
   import ct_loader_pkg::*;
#(
   parameter int N = CT_N,
   parameter int M = CT_M,
   parameter int D = CT_D,
   localparam int WIDTH = ct_width(M, D),
   localparam int AW    = ct_aw(N, D)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   output logic             busy,
   input  logic             in_valid,
   input  logic [M-1:0]     in_data,
   output logic             in_ready,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_dout,
   output logic             mem_we,
   output logic             done
);

   localparam int CW = ct_clog2(N) + 1;
   localparam int SW = (ct_clog2(D) < 1) ? 1 : ct_clog2(D);

   ct_state_t        state_reg, state_next;
   logic [CW-1:0]    elem_cnt_reg, elem_cnt_next;
   logic [SW-1:0]    slot_reg, slot_next;
   logic [AW-1:0]    row_reg, row_next;
   logic [WIDTH-1:0] pack_reg, pack_next;
   logic             we_reg, we_next;
   logic [AW-1:0]    addr_reg, addr_next;
   logic [WIDTH-1:0] dout_reg, dout_next;

   logic             hs;
   logic             last_elem;
   logic             row_full;
   logic [WIDTH-1:0] pack_ins;

   assign in_ready  = (state_reg == ST_FILL);
   assign busy      = (state_reg == ST_FILL) || (state_reg == ST_FLUSH);
   assign done      = (state_reg == ST_DONE);
   assign mem_we    = we_reg;
   assign mem_addr  = addr_reg;
   assign mem_dout  = dout_reg;

   assign hs        = in_valid && in_ready;
   assign last_elem = (elem_cnt_reg == CW'(N - 1));
   assign row_full  = (slot_reg == SW'(D - 1)) || last_elem;

   // Current pack register with the incoming element dropped into its slot;
   // untouched slots keep their contents (zero if not yet filled this row).
   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_slot
         assign pack_ins[gi*M +: M] = (slot_reg == SW'(gi)) ? in_data
                                                            : pack_reg[gi*M +: M];
      end
   endgenerate

   // State, counters, pack register and the registered RAM write port.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_reg    <= ST_IDLE;
         elem_cnt_reg <= '0;
         slot_reg     <= '0;
         row_reg      <= '0;
         pack_reg     <= '0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         dout_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         elem_cnt_reg <= elem_cnt_next;
         slot_reg     <= slot_next;
         row_reg      <= row_next;
         pack_reg     <= pack_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         dout_reg     <= dout_next;
      end
   end

   // Next-state logic: session start, per-element packing, row commit, drain.
   always_comb begin
      state_next    = state_reg;
      elem_cnt_next = elem_cnt_reg;
      slot_next     = slot_reg;
      row_next      = row_reg;
      pack_next     = pack_reg;
      we_next       = 1'b0;
      addr_next     = addr_reg;
      dout_next     = dout_reg;

      case (state_reg)
         ST_IDLE: begin
            if (load) begin
               state_next    = ST_FILL;
               elem_cnt_next = '0;
               slot_next     = '0;
               row_next      = '0;
               pack_next     = '0;
            end
         end
         ST_FILL: begin
            if (hs) begin
               elem_cnt_next = elem_cnt_reg + CW'(1);
               if (row_full) begin
                  // Commit the row (including this element) and start a fresh one.
                  we_next   = 1'b1;
                  addr_next = row_reg;
                  dout_next = pack_ins;
                  pack_next = '0;
                  slot_next = '0;
                  row_next  = row_reg + AW'(1);
               end else begin
                  pack_next = pack_ins;
                  slot_next = slot_reg + SW'(1);
               end
               if (last_elem) begin
                  state_next = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

endmodule

// File: doc/ct_loader.md
CT_LOADER -- requirements
Module: ct_loader

Interface
REQ-001 Parameter N, default `N: number of GF(2^m) ciphertext elements per load.
REQ-002 Parameter M, default `M: element width in bits.
REQ-003 Parameter D, default 5: elements per memory row.
REQ-004 Derived: WIDTH = M*D; DEPTH = ceil(N/D); AW = CLOG2(DEPTH).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_b  input  1  reset; synchronous, active-low.
REQ-007 load  input  1  pulse; starts a load session.
REQ-008 busy  output  1  high from the cycle after load is accepted until done.
REQ-009 in_valid  input  1  ciphertext element valid.
REQ-010 in_data  input  M  ciphertext element, index order 0..N-1.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 mem_addr  output  AW  row address into ciphertext single-port RAM.
REQ-013 mem_dout  output  WIDTH  packed row written to RAM.
REQ-014 mem_we  output  1  write strobe, one cycle per row.
REQ-015 done  output  1  one-cycle pulse; all DEPTH rows written; drives the decrypt start.

Function
REQ-016 FSM states: IDLE, FILL, FLUSH, DONE.
REQ-017 IDLE: in_ready=0, busy=0; load=1 -> FILL next cycle, element count and slot count cleared, pack register cleared.
REQ-018 load while not IDLE is ignored.
REQ-019 FILL: in_ready=1, busy=1; handshake = in_valid & in_ready; one element accepted per handshake, no bubbles required.
REQ-020 Element i goes to row i/D, slot i%D; slot s occupies bits [s*M+M-1 : s*M] (slot 0 at LSBs).
REQ-021 Handshake filling slot D-1, or accepting element N-1: the completed row is registered; mem_we=1, mem_addr=row index, mem_dout=row in the next cycle.
REQ-022 Pack register clears on row completion; acceptance continues uninterrupted, so a row write and a new element may coincide.
REQ-023 Unfilled slots of the final row (N%D != 0) are zero.
REQ-024 On accepting element N-1: in_ready drops next cycle, FSM -> FLUSH (final-row write cycle).
REQ-025 FLUSH -> DONE; DONE: done=1 for one cycle, busy=0, -> IDLE.
REQ-026 Latency: done asserts exactly 2 cycles after the handshake of element N-1.
REQ-027 in_valid low in FILL: no state change; gaps of any length are legal.
REQ-028 in_valid in IDLE/FLUSH/DONE: not accepted, no effect.
REQ-029 mem_we never asserts outside the cycle following a row-completing handshake; exactly DEPTH writes per session, addresses 0..DEPTH-1 ascending.
REQ-030 Element counter width CLOG2(N)+1; slot counter wraps D-1 -> 0; no other wrap-around.

Reset
REQ-031 rst_b=0 at a clock edge: FSM -> IDLE; counters and pack register cleared; in_ready=0, busy=0, mem_we=0, done=0, mem_addr=0, mem_dout=0.
REQ-032 Reset mid-session: partial row discarded, no write, no done; next load restarts at row 0.

Structure
REQ-033 WIDTH, DEPTH, AW and state encoding live in the shared decrypt constants package/define file alongside `N, `M and CLOG2.
REQ-034 Single module; packing register and FSM inline; no sub-module.
REQ-035 Its RAM port matches the ciphertext single-port RAM (1-cycle write); a top-level mux gives the port to the loader while busy, else to the multiplier.

Verification (bench params N=7, M=4, D=5 unless stated)
REQ-036 load, then elements 1..7 back-to-back -> write row0=20'h54321 @addr0, row1=20'h00076 @addr1; done 2 cycles after the 7th handshake.
REQ-037 Same data with in_valid low every other cycle -> identical writes and counts; done 2 cycles after the last handshake.
REQ-038 N=10, D=5, elements 0xA repeated -> 2 writes, both 20'hAAAAA, no zero padding, exactly 2 mem_we pulses.
REQ-039 rst_b low after 3 elements, then load and 7 new elements -> only the new session's rows written; no done before the second session.
REQ-040 load pulses while busy and in_valid held high in IDLE -> no extra handshakes, no restart, still exactly DEPTH writes.
REQ-041 Default parameters, random elements -> RAM contents equal the reference packing; busy/done/in_ready timing per REQ-024..026.
